bitstream_window_buffer: RTL and testbench

BITSTREAM_WINDOW_BUFFER -- requirements
Module: bitstream_window_buffer

---
 rtl/bitstream_window_buffer.sv | 106 ++++++++++
 tb/tb_bitstream_window_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bitstream_window_buffer.sv
// Bit-serial window over a 16-bit word stream: 48-bit left-aligned buffer with consume/byte-align.
// Optional macro BITSTREAM_BIT_COUNTER_EN adds a 32-bit total_bits_consumed output.
module bitstream_window_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  output logic        word_ready,
  input  logic        consume_en,
  input  logic [4:0]  consume_len,
  input  logic        byte_align,
  output logic [15:0] BitStream_buffer_output,
  output logic [3:0]  heading_one_pos,
  output logic        window_all_zero,
  output logic        window_valid
`ifdef BITSTREAM_BIT_COUNTER_EN
  ,
  output logic [31:0] total_bits_consumed
`endif
);

  logic [47:0] r_buf;
  logic [5:0]  r_cnt;
  logic [2:0]  r_phase;

  logic [2:0]  w_need;
  logic [4:0]  w_clen;
  logic [4:0]  w_shift;
  logic [5:0]  w_cnt_rem;
  logic        w_acc;
  logic [47:0] w_buf_sh;
  logic [47:0] w_mask;
  logic [47:0] w_ins;
  logic [47:0] w_buf_nx;
  logic [5:0]  w_cnt_nx;
  logic [3:0]  w_hop;

  assign BitStream_buffer_output = r_buf[47:32];
  assign window_valid            = (r_cnt >= 6'd16);
  assign window_all_zero         = (r_buf[47:32] == 16'h0);
  assign word_ready              = (r_cnt <= 6'd32) && !flush;
  assign w_acc                   = word_valid && word_ready;

  // Bits still needed to reach the next byte boundary.
  assign w_need = 3'd0 - r_phase;
  assign w_clen = (consume_len > 5'd16) ? 5'd16 : consume_len;

  always_comb begin
    w_shift = 5'd0;
    if (byte_align) begin
      if (r_cnt >= {3'b000, w_need})
        w_shift = {2'b00, w_need};
    end else if (consume_en && window_valid) begin
      w_shift = w_clen;
    end
  end

  // New word lands right after the surviving bits; stale bits below that point are masked off.
  always_comb begin
    w_cnt_rem = r_cnt - {1'b0, w_shift};
    w_buf_sh  = r_buf << w_shift;
    w_mask    = ~(48'hFFFF_FFFF_FFFF >> w_cnt_rem);
    w_ins     = {word_data, 32'h0} >> w_cnt_rem;
    w_buf_nx  = w_buf_sh;
    w_cnt_nx  = w_cnt_rem;
    if (w_acc) begin
      w_buf_nx = (w_buf_sh & w_mask) | w_ins;
      w_cnt_nx = w_cnt_rem + 6'd16;
    end
  end

  always_comb begin
    w_hop = 4'd15;
    for (int i = 0; i < 16; i++)
      if (r_buf[32+i]) w_hop = 4'(15 - i);
  end
  assign heading_one_pos = w_hop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (flush) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
    end else begin
      r_buf   <= w_buf_nx;
      r_cnt   <= w_cnt_nx;
      r_phase <= r_phase + w_shift[2:0];
    end
  end

`ifdef BITSTREAM_BIT_COUNTER_EN
  logic [31:0] r_total;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_total <= '0;
    else if (flush) r_total <= '0;
    else            r_total <= r_total + {27'd0, w_shift};
  end
  assign total_bits_consumed = r_total;
`endif

endmodule

// File: tb/tb_bitstream_window_buffer.sv
// Directed table-driven bench for bitstream_window_buffer plus reset/throughput sequences.
module tb_bitstream_window_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, word_valid, consume_en, byte_align;
  logic [15:0] word_data;
  logic [4:0]  consume_len;
  logic        word_ready, window_all_zero, window_valid;
  logic [15:0] win;
  logic [3:0]  hop;
`ifdef BITSTREAM_BIT_COUNTER_EN
  logic [31:0] total_bits_consumed;
`endif

  int total = 0;
  int bad   = 0;

  bitstream_window_buffer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .consume_en(consume_en), .consume_len(consume_len), .byte_align(byte_align),
    .BitStream_buffer_output(win), .heading_one_pos(hop),
    .window_all_zero(window_all_zero), .window_valid(window_valid)
`ifdef BITSTREAM_BIT_COUNTER_EN
    , .total_bits_consumed(total_bits_consumed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, wv;
    logic [15:0] wd;
    logic        ce;
    logic [4:0]  cl;
    logic        ba;
    logic [15:0] e_win;
    logic [3:0]  e_hop;
    logic        e_waz, e_wval, e_wrdy;
    logic [5:0]  e_cnt;
    logic [31:0] e_tot;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic fl, input logic wv, input logic [15:0] wd,
                              input logic ce, input logic [4:0] cl, input logic ba,
                              input logic [15:0] w, input logic [3:0] h, input logic z,
                              input logic v, input logic r, input logic [5:0] c,
                              input logic [31:0] t);
    vec_t x;
    x.fl = fl; x.wv = wv; x.wd = wd; x.ce = ce; x.cl = cl; x.ba = ba;
    x.e_win = w; x.e_hop = h; x.e_waz = z; x.e_wval = v; x.e_wrdy = r;
    x.e_cnt = c; x.e_tot = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; word_valid = 0; word_data = 16'h0;
    consume_en = 0; consume_len = 5'd0; byte_align = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " win"},   {16'h0, win}, 32'h0);
    chk({tag, " hop"},   {28'h0, hop}, 32'd15);
    chk({tag, " waz"},   {31'h0, window_all_zero}, 32'd1);
    chk({tag, " wval"},  {31'h0, window_valid}, 32'd0);
    chk({tag, " wrdy"},  {31'h0, word_ready}, 32'd1);
    chk({tag, " cnt"},   {26'h0, dut.r_cnt}, 32'd0);
`ifdef BITSTREAM_BIT_COUNTER_EN
    chk({tag, " total"}, total_bits_consumed, 32'd0);
`endif
  endtask

  initial begin
    //             fl wv wd       ce cl  ba   win      hop z v r cnt tot
    vecs[0]  = mk(0, 1, 16'h8000, 0, 0,  0, 16'h8000, 0, 0,1,1, 16, 0);
    vecs[1]  = mk(0, 1, 16'h0001, 0, 0,  0, 16'h8000, 0, 0,1,1, 32, 0);
    vecs[2]  = mk(0, 0, 16'h0,    1, 1,  0, 16'h0000,15, 1,1,1, 31, 1);
    vecs[3]  = mk(0, 0, 16'h0,    1, 15, 0, 16'h0001,15, 0,1,1, 16, 16);
    vecs[4]  = mk(0, 0, 16'h0,    1, 16, 0, 16'h0000,15, 1,0,1, 0,  32);
    vecs[5]  = mk(0, 1, 16'hA5A5, 0, 0,  0, 16'hA5A5, 0, 0,1,1, 16, 32);
    vecs[6]  = mk(0, 1, 16'h1234, 0, 0,  0, 16'hA5A5, 0, 0,1,1, 32, 32);
    vecs[7]  = mk(0, 1, 16'hFFFF, 0, 0,  0, 16'hA5A5, 0, 0,1,0, 48, 32);
    vecs[8]  = mk(0, 1, 16'h5555, 1, 16, 0, 16'h1234, 3, 0,1,1, 32, 48);
    vecs[9]  = mk(0, 1, 16'h5555, 1, 0,  0, 16'h1234, 3, 0,1,0, 48, 48);
    vecs[10] = mk(0, 0, 16'h0,    1, 3,  0, 16'h91A7, 0, 0,1,0, 45, 51);
    vecs[11] = mk(0, 0, 16'h0,    1, 16, 1, 16'h34FF, 2, 0,1,0, 40, 56);
    vecs[12] = mk(0, 0, 16'h0,    0, 0,  1, 16'h34FF, 2, 0,1,0, 40, 56);
    vecs[13] = mk(0, 0, 16'h0,    1, 20, 0, 16'hFF55, 0, 0,1,1, 24, 72);
    vecs[14] = mk(0, 0, 16'h0,    1, 14, 0, 16'h5540, 1, 0,0,1, 10, 86);
    vecs[15] = mk(0, 0, 16'h0,    1, 4,  0, 16'h5540, 1, 0,0,1, 10, 86);
    vecs[16] = mk(1, 1, 16'hFFFF, 1, 16, 1, 16'h0000,15, 1,0,1, 0,  0);
    vecs[17] = mk(0, 1, 16'h0F00, 0, 0,  0, 16'h0F00, 4, 0,1,1, 16, 0);
    vecs[18] = mk(0, 1, 16'h00FF, 0, 0,  0, 16'h0F00, 4, 0,1,1, 32, 0);
    vecs[19] = mk(0, 1, 16'hC000, 1, 5,  0, 16'hE000, 0, 0,1,0, 43, 5);
    vecs[20] = mk(0, 0, 16'h0,    0, 0,  1, 16'h0000,15, 1,1,0, 40, 8);
    vecs[21] = mk(0, 0, 16'h0,    1, 16, 0, 16'hFFC0, 0, 0,1,1, 24, 24);
    vecs[22] = mk(0, 0, 16'h0,    1, 3,  0, 16'hFE00, 0, 0,1,1, 21, 27);
    vecs[23] = mk(0, 1, 16'h1111, 0, 0,  0, 16'hFE00, 0, 0,1,0, 37, 27);

    idle();
    reset_n = 0;
    #12;
    chk_reset_outs("por");
    @(negedge clk);
    reset_n = 1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      flush = vecs[i].fl; word_valid = vecs[i].wv; word_data = vecs[i].wd;
      consume_en = vecs[i].ce; consume_len = vecs[i].cl; byte_align = vecs[i].ba;
      @(posedge clk);
      #1 idle();
      #1;
      chk($sformatf("v%0d win", i),  {16'h0, win}, {16'h0, vecs[i].e_win});
      chk($sformatf("v%0d hop", i),  {28'h0, hop}, {28'h0, vecs[i].e_hop});
      chk($sformatf("v%0d waz", i),  {31'h0, window_all_zero}, {31'h0, vecs[i].e_waz});
      chk($sformatf("v%0d wval", i), {31'h0, window_valid}, {31'h0, vecs[i].e_wval});
      chk($sformatf("v%0d wrdy", i), {31'h0, word_ready}, {31'h0, vecs[i].e_wrdy});
      chk($sformatf("v%0d cnt", i),  {26'h0, dut.r_cnt}, {26'h0, vecs[i].e_cnt});
`ifdef BITSTREAM_BIT_COUNTER_EN
      chk($sformatf("v%0d total", i), total_bits_consumed, vecs[i].e_tot);
`endif
    end

    // Asynchronous reset mid-stream with 37 bits buffered.
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    reset_n = 1;

    // First word after release lands at the top of the window.
    word_valid = 1; word_data = 16'hABCD;
    @(posedge clk);
    #1 idle();
    #1;
    chk("post-rst win", {16'h0, win}, 32'h0000ABCD);
    chk("post-rst cnt", {26'h0, dut.r_cnt}, 32'd16);

    // Sustained 16-bit consume with a new word every cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      word_valid = 1; word_data = 16'h1000 + 16'(k);
      consume_en = 1; consume_len = 5'd16;
      @(posedge clk);
      #1 idle();
      #1;
      chk($sformatf("tp%0d win", k), {16'h0, win}, {16'h0, 16'h1000 + 16'(k)});
      chk($sformatf("tp%0d cnt", k), {26'h0, dut.r_cnt}, 32'd16);
      chk($sformatf("tp%0d wrdy", k), {31'h0, word_ready}, 32'd1);
    end
`ifdef BITSTREAM_BIT_COUNTER_EN
    chk("tp total", total_bits_consumed, 32'd48);
    @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1 idle();
    #1;
    chk("flush total", total_bits_consumed, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
